// File: rtl/serial_borrow_lookahead_subtractor_pkg.sv
// Shared constants and types for the serial borrow-lookahead subtractor:
// slice width, FSM state encoding and the slice-count helper.
package serial_borrow_lookahead_subtractor_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int calc_nslice(input int width);
    return width / SLICE_W;
  endfunction

endpackage

// File: rtl/serial_borrow_lookahead_subtractor_slice.sv
// Combinational 4-bit subtract slice: d = a - b - bin, with every internal
// borrow resolved directly from propagate/generate terms rather than rippled.
module borrow_lookahead_4bit
  import serial_borrow_lookahead_subtractor_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               bin,
  output logic [SLICE_W-1:0] d,
  output logic               bout
);

  logic [SLICE_W-1:0] w_p;
  logic [SLICE_W-1:0] w_g;
  logic [SLICE_W-1:0] w_br;

  // A bit propagates an incoming borrow when a == b, and generates one when a=0, b=1.
  assign w_p = ~(a ^ b);
  assign w_g = ~a & b;

  assign w_br[0] = bin;
  assign w_br[1] = w_g[0] | (w_p[0] & bin);
  assign w_br[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & bin);
  assign w_br[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                 | (w_p[2] & w_p[1] & w_p[0] & bin);

  assign bout = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
              | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
              | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & bin);

  assign d = a ^ b ^ w_br;

endmodule

// File: rtl/serial_borrow_lookahead_subtractor.sv
// Multi-cycle D = A - B - Bin: one 4-bit lookahead slice per clock, LSB slice
// first, borrow carried between slices in a register; valid/ready on both sides.
module serial_borrow_lookahead_subtractor
  import serial_borrow_lookahead_subtractor_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             Ovf,
  output logic             busy
);

  localparam int              NSLICE = calc_nslice(WIDTH);
  localparam int              CNT_W  = $clog2(NSLICE);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(NSLICE - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_d;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_borrow;
  logic               r_bout;
  logic               r_ovf;
  logic [SLICE_W-1:0] w_a_sl;
  logic [SLICE_W-1:0] w_b_sl;
  logic [SLICE_W-1:0] w_d_sl;
  logic               w_bout_sl;
  logic               w_accept;
  logic               w_last;

  assign w_accept = in_valid && (r_state == IDLE);
  assign w_last   = (r_cnt == LAST);
  assign w_a_sl   = r_a[r_cnt*SLICE_W +: SLICE_W];
  assign w_b_sl   = r_b[r_cnt*SLICE_W +: SLICE_W];

  borrow_lookahead_4bit u_slice (
    .a    (w_a_sl),
    .b    (w_b_sl),
    .bin  (r_borrow),
    .d    (w_d_sl),
    .bout (w_bout_sl)
  );

  // NOTE: clocked state uses non-blocking assignments so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: every output of this block is defaulted first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_d      <= '0;
      r_cnt    <= '0;
      r_borrow <= 1'b0;
      r_bout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_accept) begin
      r_a      <= A;
      r_b      <= B;
      r_cnt    <= '0;
      r_borrow <= Bin;
    end else if (r_state == RUN) begin
      r_d[r_cnt*SLICE_W +: SLICE_W] <= w_d_sl;
      r_borrow <= w_bout_sl;
      if (w_last) begin
        // The counter parks on the last slice until the next accept reloads it.
        r_bout <= w_bout_sl;
        r_ovf  <= (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_d_sl[SLICE_W-1] != r_a[WIDTH-1]);
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign D    = r_d;
  assign Bout = r_bout;
  assign Ovf  = r_ovf;

endmodule

// File: tb/tb_serial_borrow_lookahead_subtractor.sv
// Self-checking bench: directed corner cases plus 1000 random operations
// compared against an integer-arithmetic reference model.
module tb_serial_borrow_lookahead_subtractor;

  localparam int WIDTH   = 16;
  localparam int LATENCY = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] D;
  logic             Bout;
  logic             Ovf;
  logic             busy;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  serial_borrow_lookahead_subtractor #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Bin       (Bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .D         (D),
    .Bout      (Bout),
    .Ovf       (Ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: plain integer subtraction, unsigned for D/Bout, signed range for Ovf.
  task automatic ref_model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic bin, output logic [WIDTH-1:0] d,
                           output logic bo, output logic ov);
    int du;
    int ds;
    du = int'(a) - int'(b) - int'(bin);
    ds = int'($signed(a)) - int'($signed(b)) - int'(bin);
    d  = du[WIDTH-1:0];
    bo = (du < 0);
    ov = (ds > 32767) || (ds < -32768);
  endtask

  // All tasks start and end #1 after a rising edge.
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic bin, output int acc);
    int waited = 0;
    while (!in_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) check("in_ready_wait", 32'(in_ready), 32'd1);
    A = a; B = b; Bin = bin; in_valid = 1'b1;
    @(posedge clk); #1;
    acc = cyc;
    in_valid = 1'b0;
    A = 16'($urandom); B = 16'($urandom); Bin = 1'($urandom);
  endtask

  task automatic wait_result(input int acc, input logic [WIDTH-1:0] a,
                             input logic [WIDTH-1:0] b, input logic bin);
    logic [WIDTH-1:0] ed;
    logic             eb;
    logic             eo;
    int               n = 0;
    ref_model(a, b, bin, ed, eb, eo);
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", 32'(cyc - acc), 32'(LATENCY));
    check("D",    32'(D),    32'(ed));
    check("Bout", 32'(Bout), 32'(eb));
    check("Ovf",  32'(Ovf),  32'(eo));
  endtask

  task automatic drain(input bit rnd);
    int n = 0;
    do begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      n++;
    end while (!out_ready && n < 200);
    out_ready = 1'b0;
    check("drain_out_valid", 32'(out_valid), 32'd0);
    check("drain_in_ready",  32'(in_ready),  32'd1);
  endtask

  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic bin, input bit rnd);
    int acc;
    send(a, b, bin, acc);
    wait_result(acc, a, b, bin);
    drain(rnd);
  endtask

  initial begin
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic             rbin;
    int               acc;
    bit               seen_valid;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; Bin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_D",         32'(D),         32'd0);
    check("rst_Bout",      32'(Bout),      32'd0);
    check("rst_Ovf",       32'(Ovf),       32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases, including busy/in_ready during RUN.
    send(16'h1234, 16'h0234, 1'b0, acc);
    check("run_busy",     32'(busy),     32'd1);
    check("run_in_ready", 32'(in_ready), 32'd0);
    wait_result(acc, 16'h1234, 16'h0234, 1'b0);
    drain(1'b0);
    run_op(16'h0000, 16'h0000, 1'b1, 1'b0);
    run_op(16'h8000, 16'h0001, 1'b0, 1'b0);
    run_op(16'hABCD, 16'hABCD, 1'b0, 1'b0);
    run_op(16'h7FFF, 16'hFFFF, 1'b0, 1'b0);

    // DONE held with out_ready low while in_valid toggles with fresh operands.
    send(16'h0F0F, 16'h0101, 1'b1, acc);
    wait_result(acc, 16'h0F0F, 16'h0101, 1'b1);
    for (int i = 0; i < 10; i++) begin
      in_valid = (i % 2 == 0);
      A = 16'($urandom); B = 16'($urandom); Bin = 1'($urandom);
      @(posedge clk); #1;
      check("hold_D",         32'(D),         32'h0E0D);
      check("hold_Bout",      32'(Bout),      32'd0);
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready",  32'(in_ready),  32'd0);
    end
    in_valid = 1'b0;
    drain(1'b0);

    // Asynchronous reset during the second RUN cycle discards the operation.
    send(16'hFFFF, 16'h0001, 1'b0, acc);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready",  32'(in_ready),  32'd1);
    check("mid_rst_busy",      32'(busy),      32'd0);
    check("mid_rst_D",         32'(D),         32'd0);
    check("mid_rst_Bout",      32'(Bout),      32'd0);
    check("mid_rst_Ovf",       32'(Ovf),       32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen_valid = 1'b1;
    end
    check("post_rst_no_valid", 32'(seen_valid), 32'd0);
    run_op(16'h0005, 16'h0007, 1'b0, 1'b0);

    // Random back-to-back operations with a 50% out_ready consumer.
    for (int i = 0; i < 1000; i++) begin
      ra   = 16'($urandom);
      rb   = ($urandom_range(0, 7) == 0) ? ra : 16'($urandom);
      rbin = 1'($urandom);
      run_op(ra, rb, rbin, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
